// File: rtl/diferential_muxpga_pkg.sv
// Shared types and helpers for the differential muxpga fabric.
//   cmd_e      : bus command (config shift, run, peek, readback)
//   op_e       : logic-cell operation selected by cfg[2:0]
//   sel_e      : neighbour direction selected by each 2-bit mux field
//   cfg_idx()  : chain word index of a cell's mux nibble (cfg nibble follows it)
//   wrap()     : non-negative modulo used for torus routing
package diferential_muxpga_pkg;

  localparam int CFG_WORD_W = 4;

  typedef enum logic [1:0] {
    CMD_CFG      = 2'd0,
    CMD_RUN      = 2'd1,
    CMD_PEEK     = 2'd2,
    CMD_READBACK = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    OP_OR   = 3'd0,
    OP_AND  = 3'd1,
    OP_IN1  = 3'd2,
    OP_IN2  = 3'd3,
    OP_XOR  = 3'd4,
    OP_ADD  = 3'd5,
    OP_NOT  = 3'd6,
    OP_HOLD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    SEL_UP    = 2'd0,
    SEL_DOWN  = 2'd1,
    SEL_LEFT  = 2'd2,
    SEL_RIGHT = 2'd3
  } sel_e;

  function automatic int cfg_idx(input int r, input int c, input int cols);
    return 2 * ((r - 1) * cols + c);
  endfunction

  function automatic int wrap(input int x, input int n);
    return ((x % n) + n) % n;
  endfunction

endpackage

// File: rtl/diferential_muxpga_gen_lcell.sv
// One B-bit logic cell: operation ALU, optional output inversion and an
// enable-gated result register.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low clear
//   en_i   : load the ALU result this cycle (RUN only)
//   cfg_i  : {invert, op[2:0]}
//   in1_i  : first operand (selected neighbour)
//   in2_i  : second operand (selected neighbour)
//   q_o    : registered cell value
module diferential_lcell
  import diferential_muxpga_pkg::*;
#(
  parameter int B = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [CFG_WORD_W-1:0] cfg_i,
  input  logic [B-1:0]          in1_i,
  input  logic [B-1:0]          in2_i,
  output logic [B-1:0]          q_o
);

  logic [B-1:0] q_q;
  logic [B-1:0] q_d;

  always_comb begin
    q_d = q_q;
    case (op_e'(cfg_i[2:0]))
      OP_OR:   q_d = in1_i | in2_i;
      OP_AND:  q_d = in1_i & in2_i;
      OP_IN1:  q_d = in1_i;
      OP_IN2:  q_d = in2_i;
      OP_XOR:  q_d = in1_i ^ in2_i;
      OP_ADD:  q_d = in1_i + in2_i;
      OP_NOT:  q_d = ~in1_i;
      OP_HOLD: q_d = q_q;
      default: q_d = q_q;
    endcase
    // Inversion applies to every op, so hold+invert toggles the cell.
    if (cfg_i[3]) q_d = ~q_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/diferential_muxpga_gen.sv
// ROWS x COLS torus of B-bit logic cells; row 0 is the din input row.
// Configuration lives in a nibble shift chain (two words per cell) that can
// be rotated for non-destructive readback.
//   clk          : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   cmd          : 0 CFG, 1 RUN, 2 PEEK, 3 READBACK
//   din          : row-0 data / config nibble (din[3:0]) / peek index
//   dout         : observation bus, combinational from state, cmd and din
//   cfg_done     : a full chain's worth of nibbles shifted since reset
//   cycle_count  : RUN cycles since reset, wrapping
module diferential_muxpga_gen
  import diferential_muxpga_pkg::*;
#(
  parameter int ROWS  = 5,
  parameter int COLS  = 3,
  parameter int B     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       cmd,
  input  logic [B-1:0]     din,
  output logic [2*B-1:0]   dout,
  output logic             cfg_done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int NCELL     = (ROWS - 1) * COLS;
  localparam int CFG_WORDS = 2 * NCELL;
  localparam int CC_W      = $clog2(CFG_WORDS + 1);

  cmd_e cmd_w;
  logic run_en;

  logic [CFG_WORD_W-1:0] chain_q [CFG_WORDS];
  logic [CFG_WORD_W-1:0] chain_d [CFG_WORDS];
  logic [CC_W-1:0]       cfg_cnt_q;
  logic [CC_W-1:0]       cfg_cnt_d;
  logic [CNT_W-1:0]      cyc_q;
  logic [CNT_W-1:0]      cyc_d;

  // Flattened view of the whole grid; row 0 entries all carry din so that
  // every neighbour lookup is a plain index.
  logic [B-1:0] node [ROWS*COLS];
  logic [B-1:0] peek_val;

  assign cmd_w  = cmd_e'(cmd);
  assign run_en = (cmd_w == CMD_RUN);

  // Config chain: CFG shifts din in at word 0, READBACK rotates the last
  // word back to word 0 so a full rotation restores the chain.
  always_comb begin
    for (int i = 0; i < CFG_WORDS; i++) chain_d[i] = chain_q[i];
    if (cmd_w == CMD_CFG) begin
      chain_d[0] = din[CFG_WORD_W-1:0];
      for (int i = 1; i < CFG_WORDS; i++) chain_d[i] = chain_q[i-1];
    end else if (cmd_w == CMD_READBACK) begin
      chain_d[0] = chain_q[CFG_WORDS-1];
      for (int i = 1; i < CFG_WORDS; i++) chain_d[i] = chain_q[i-1];
    end
  end

  always_comb begin
    cfg_cnt_d = cfg_cnt_q;
    if ((cmd_w == CMD_CFG) && (cfg_cnt_q != CC_W'(CFG_WORDS))) begin
      cfg_cnt_d = cfg_cnt_q + CC_W'(1);
    end
  end

  always_comb begin
    cyc_d = cyc_q;
    if (run_en) cyc_d = cyc_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CFG_WORDS; i++) chain_q[i] <= '0;
      cfg_cnt_q <= '0;
      cyc_q     <= '0;
    end else begin
      for (int i = 0; i < CFG_WORDS; i++) chain_q[i] <= chain_d[i];
      cfg_cnt_q <= cfg_cnt_d;
      cyc_q     <= cyc_d;
    end
  end

  assign cfg_done    = (cfg_cnt_q == CC_W'(CFG_WORDS));
  assign cycle_count = cyc_q;

  for (genvar c = 0; c < COLS; c++) begin : g_in_row
    assign node[c] = din;
  end

  for (genvar r = 1; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int K  = cfg_idx(r, c, COLS);
      localparam int UP = (r - 1) * COLS + c;
      localparam int DN = wrap(r + 1, ROWS) * COLS + c;
      localparam int LF = r * COLS + wrap(c - 1, COLS);
      localparam int RT = r * COLS + wrap(c + 1, COLS);

      logic [B-1:0] src [4];
      logic [B-1:0] in1;
      logic [B-1:0] in2;

      assign src[SEL_UP]    = node[UP];
      assign src[SEL_DOWN]  = node[DN];
      assign src[SEL_LEFT]  = node[LF];
      assign src[SEL_RIGHT] = node[RT];

      assign in1 = src[chain_q[K][1:0]];
      assign in2 = src[chain_q[K][3:2]];

      diferential_lcell #(.B(B)) u_cell (
        .clk   (clk),
        .rst_n (reset_n),
        .en_i  (run_en),
        .cfg_i (chain_q[K+1]),
        .in1_i (in1),
        .in2_i (in2),
        .q_o   (node[r*COLS+c])
      );
    end
  end

  always_comb begin
    peek_val = '0;
    for (int i = 0; i < NCELL; i++) begin
      if (int'(din) == i) peek_val = node[COLS+i];
    end
  end

  always_comb begin
    dout = '0;
    case (cmd_w)
      CMD_CFG, CMD_READBACK: dout = {chain_q[CFG_WORDS-1], {(2*B-CFG_WORD_W){1'b0}}};
      CMD_RUN:               dout = {node[ROWS*COLS-2], node[ROWS*COLS-1]};
      CMD_PEEK:              dout = {{B{1'b0}}, peek_val};
      default:               dout = '0;
    endcase
  end

endmodule

// File: tb/tb_diferential_muxpga_gen.sv
module tb_diferential_muxpga_gen;

  localparam int ROWS  = 5;
  localparam int COLS  = 3;
  localparam int B     = 4;
  localparam int CNT_W = 16;
  localparam int NCELL = (ROWS - 1) * COLS;
  localparam int NW    = 2 * NCELL;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       cmd = 2'd2;
  logic [B-1:0]     din = '0;
  logic [2*B-1:0]   dout;
  logic             cfg_done;
  logic [CNT_W-1:0] cycle_count;

  int tests = 0;
  int fails = 0;
  bit quiet = 1'b0;

  // Reference state: cell values by (row, col), chain as a queue where
  // element 0 is word 0.
  int m_q [ROWS][COLS];
  int m_chain [$];
  int m_cfgcnt;
  int m_cyc;

  int w [NW];
  int rn [NW];

  always #5 clk = ~clk;

  diferential_muxpga_gen #(.ROWS(ROWS), .COLS(COLS), .B(B), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd         (cmd),
    .din         (din),
    .dout        (dout),
    .cfg_done    (cfg_done),
    .cycle_count (cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_chain.delete();
    repeat (NW) m_chain.push_back(0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_q[r][c] = 0;
    m_cfgcnt = 0;
    m_cyc = 0;
  endfunction

  function automatic int src_val(input int r, input int c, input int sel, input int d);
    int sr = r;
    int sc = c;
    case (sel)
      0: sr = r - 1;
      1: sr = (r + 1) % ROWS;
      2: sc = (c + COLS - 1) % COLS;
      default: sc = (c + 1) % COLS;
    endcase
    return (sr == 0) ? d : m_q[sr][sc];
  endfunction

  function automatic void model_step(input int c_in, input int d);
    int nq [ROWS][COLS];
    int mx, cf, a, b, res, t;
    case (c_in)
      0: begin
        m_chain.push_front(d % 16);
        t = m_chain.pop_back();
        if (m_cfgcnt < NW) m_cfgcnt++;
      end
      1: begin
        for (int r = 1; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            mx = m_chain[2 * ((r - 1) * COLS + c)];
            cf = m_chain[2 * ((r - 1) * COLS + c) + 1];
            a = src_val(r, c, mx % 4, d);
            b = src_val(r, c, mx / 4, d);
            case (cf % 8)
              0: res = a | b;
              1: res = a & b;
              2: res = a;
              3: res = b;
              4: res = a ^ b;
              5: res = (a + b) % 16;
              6: res = 15 - a;
              default: res = m_q[r][c];
            endcase
            if (cf >= 8) res = 15 - res;
            nq[r][c] = res;
          end
        end
        for (int r = 1; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) m_q[r][c] = nq[r][c];
        m_cyc = (m_cyc + 1) % 65536;
      end
      3: m_chain.push_front(m_chain.pop_back());
      default: ;
    endcase
  endfunction

  function automatic int m_dout(input int c_in, input int d);
    case (c_in)
      0, 3: return m_chain[NW-1] * 16;
      1:    return m_q[ROWS-1][COLS-2] * 16 + m_q[ROWS-1][COLS-1];
      default: return (d < NCELL) ? m_q[1 + d / COLS][d % COLS] : 0;
    endcase
  endfunction

  // One clock with the given command: checks dout before the edge and the
  // counters/flag after it against the reference.
  task automatic step(input int c_in, input int d);
    cmd = 2'(c_in);
    din = B'(d);
    @(negedge clk);
    if (!quiet) chk("dout_pre", 32'(dout), 32'(m_dout(c_in, d)));
    @(posedge clk);
    model_step(c_in, d);
    #1;
    if (!quiet) begin
      chk("cfg_done", 32'(cfg_done), (m_cfgcnt == NW) ? 32'd1 : 32'd0);
      chk("cycle_count", 32'(cycle_count), 32'(m_cyc));
    end
  endtask

  task automatic load_cfg();
    for (int i = NW - 1; i >= 0; i--) step(0, w[i]);
  endtask

  task automatic uniform_cfg(input int mx, input int cf);
    for (int k = 0; k < NW; k++) w[k] = (k % 2 == 0) ? mx : cf;
  endtask

  task automatic peek_chk(input string tag, input int idx, input int exp);
    cmd = 2'd2;
    din = B'(idx);
    #1;
    chk(tag, 32'(dout), 32'(exp));
  endtask

  // Asynchronous reset applied between edges while RUN is on the bus.
  task automatic do_reset(input string tag);
    cmd = 2'd1;
    din = B'($urandom_range(1, 15));
    #2;
    reset_n = 1'b0;
    #1;
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_cfg_done"}, 32'(cfg_done), 32'd0);
    chk({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
    model_reset();
    cmd = 2'd2;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    do_reset("reset");

    // Config count boundary and pre-edge view of the first nibble.
    for (int i = 0; i < NW; i++) rn[i] = $urandom_range(0, 15);
    for (int i = 0; i < NW - 1; i++) step(0, rn[i]);
    chk("cfg_done_23", 32'(cfg_done), 32'd0);
    step(0, rn[NW-1]);
    chk("cfg_done_24", 32'(cfg_done), 32'd1);
    cmd = 2'd0;
    din = B'($urandom_range(0, 15));
    @(negedge clk);
    chk("first_nibble", 32'(dout[7:4]), 32'(rn[0]));
    @(posedge clk);
    model_step(0, int'(din));
    #1;
    chk("cfg_done_25", 32'(cfg_done), 32'd1);

    // Pass-through column: din reaches the bottom row on the 4th RUN edge.
    uniform_cfg(0, 2);
    load_cfg();
    for (int i = 0; i < 3; i++) step(1, 10);
    chk("run3_dout", 32'(dout), 32'h00);
    step(1, 10);
    chk("run4_dout", 32'(dout), 32'hAA);
    chk("run4_count", 32'(cycle_count), 32'd4);

    // Readback replays the chain in shift-in order and leaves it intact.
    for (int i = 0; i < NW; i++) begin
      cmd = 2'd3;
      din = B'($urandom_range(0, 15));
      @(negedge clk);
      chk("readback_nib", 32'(dout[7:4]), 32'(w[NW-1-i]));
      @(posedge clk);
      model_step(3, int'(din));
      #1;
    end
    chk("readback_cfg_done", 32'(cfg_done), 32'd1);
    peek_chk("readback_cells", 5, 10);
    for (int i = 0; i < 4; i++) step(1, 5);
    chk("rerun_55", 32'(dout), 32'h55);
    for (int i = 0; i < 4; i++) step(1, 10);
    chk("rerun_AA", 32'(dout), 32'hAA);

    // Adder cell, then the same with inversion.
    uniform_cfg(0, 2);
    w[1] = 5;
    load_cfg();
    step(1, 9);
    peek_chk("peek_add", 0, 8'h02);
    w[1] = 13;
    load_cfg();
    peek_chk("peek_hold_cfg", 0, 8'h02);
    step(1, 9);
    peek_chk("peek_add_inv", 0, 8'h0D);

    for (int i = 0; i < 4; i++) step(1, 10);
    chk("pre_reset_dout", 32'(dout), 32'hAA);
    do_reset("midrun_reset");

    // Random config and random command mix against the reference.
    for (int i = 0; i < NW; i++) w[i] = $urandom_range(0, 15);
    load_cfg();
    for (int i = 0; i < 400; i++) step($urandom_range(0, 3), $urandom_range(0, 15));

    // Counter wrap and out-of-range peek.
    do_reset("wrap_reset");
    quiet = 1'b1;
    for (int i = 0; i < 65537; i++) step(1, $urandom_range(0, 15));
    quiet = 1'b0;
    chk("wrap_count", 32'(cycle_count), 32'd1);
    peek_chk("peek_12", 12, 0);
    peek_chk("peek_15", 15, 0);
    peek_chk("peek_11", 11, m_dout(2, 11));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
